// File: rtl/uart_ram1_ctrl.sv
// Single-word load/store sequencer for the shared RAM1 bus and CPLD UART strobes.
// Define UART_TIMEOUT_EN to bound the UART handshake waits by TIMEOUT cycles (err on expiry).
module uart_ram1_ctrl #(
    parameter int          RAM_CYC        = 2,
    parameter int          WR_PULSE       = 2,
    parameter int          RD_PULSE       = 2,
    parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
    parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
    parameter int          TIMEOUT        = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err,
    input  logic        tbre,
    input  logic        tsre,
    input  logic        dataReady,
    output logic        rdn,
    output logic        wrn,
    output logic        ram1En,
    output logic        ram1Oe,
    output logic        ram1We,
    output logic [17:0] ram1Addr,
    inout  wire  [15:0] ram1Data
);

`ifdef UART_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam logic [15:0] RAM_LAST = 16'(RAM_CYC - 1);
    localparam logic [15:0] WR_LAST  = 16'(WR_PULSE - 1);
    localparam logic [15:0] RD_LAST  = 16'(RD_PULSE - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE,
        RAM_RD,
        RAM_WR,
        U_WR_SETUP,
        U_WR_PULSE,
        U_WR_TBRE,
        U_WR_TSRE,
        U_RD_WAIT,
        U_RD_PULSE,
        DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] pcnt_reg, pcnt_next;
    logic [15:0] tmo_reg, tmo_next;
    logic [15:0] rdata_reg, rdata_next;
    logic [15:0] dout_reg, dout_next;
    logic [17:0] addr_reg, addr_next;
    logic        err_reg, err_next;
    logic        ready_reg, ready_next;
    logic        busy_reg, busy_next;
    logic        rdn_reg, rdn_next;
    logic        wrn_reg, wrn_next;
    logic        en_reg, en_next;
    logic        oe_reg, oe_next;
    logic        we_reg, we_next;
    logic        drive_reg, drive_next;
    logic        tmo_hit;

    assign tmo_hit = TMO_EN && (tmo_reg == TMO_LAST);

    always_comb begin
        state_next = state_reg;
        pcnt_next  = pcnt_reg + 16'd1;
        tmo_next   = (tmo_reg == 16'hFFFF) ? tmo_reg : tmo_reg + 16'd1;
        rdata_next = rdata_reg;
        dout_next  = dout_reg;
        addr_next  = addr_reg;
        err_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req) begin
                    addr_next = {2'b00, addr};
                    dout_next = wdata;
                    if (addr == UART_DATA_ADDR) begin
                        dout_next  = {8'h00, wdata[7:0]};
                        state_next = we ? U_WR_SETUP : U_RD_WAIT;
                    end else if (addr == UART_STAT_ADDR) begin
                        state_next = DONE;
                        if (!we) begin
                            rdata_next = {14'b0, dataReady, tbre & tsre};
                        end
                    end else begin
                        state_next = we ? RAM_WR : RAM_RD;
                    end
                end
            end
            RAM_RD: begin
                if (pcnt_reg == RAM_LAST) begin
                    rdata_next = ram1Data;
                    state_next = DONE;
                end
            end
            RAM_WR: begin
                if (pcnt_reg == RAM_LAST) begin
                    state_next = DONE;
                end
            end
            U_WR_SETUP: state_next = U_WR_PULSE;
            U_WR_PULSE: begin
                if (pcnt_reg == WR_LAST) begin
                    state_next = U_WR_TBRE;
                end
            end
            U_WR_TBRE: begin
                if (tbre) begin
                    state_next = U_WR_TSRE;
                end else if (tmo_hit) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                end
            end
            U_WR_TSRE: begin
                if (tsre) begin
                    state_next = DONE;
                end else if (tmo_hit) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                end
            end
            U_RD_WAIT: begin
                if (dataReady) begin
                    state_next = U_RD_PULSE;
                end else if (tmo_hit) begin
                    // A timed-out read never strobes rdn and returns all ones.
                    state_next = DONE;
                    err_next   = 1'b1;
                    rdata_next = 16'hFFFF;
                end
            end
            U_RD_PULSE: begin
                if (pcnt_reg == RD_LAST) begin
                    rdata_next = {8'h00, ram1Data[7:0]};
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (state_next != state_reg) begin
            pcnt_next = '0;
            tmo_next  = '0;
        end

        // Strobes are decoded from the upcoming state so every pin comes straight from a flop.
        ready_next = (state_next == DONE);
        busy_next  = (state_next != IDLE);
        en_next    = !((state_next == RAM_RD) || (state_next == RAM_WR));
        oe_next    = !(state_next == RAM_RD);
        we_next    = !(state_next == RAM_WR);
        wrn_next   = !(state_next == U_WR_PULSE);
        rdn_next   = !(state_next == U_RD_PULSE);
        drive_next = (state_next == RAM_WR) || (state_next == U_WR_SETUP) ||
                     (state_next == U_WR_PULSE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_reg  <= '0;
            tmo_reg   <= '0;
            rdata_reg <= '0;
            dout_reg  <= '0;
            addr_reg  <= '0;
            err_reg   <= 1'b0;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b0;
            rdn_reg   <= 1'b1;
            wrn_reg   <= 1'b1;
            en_reg    <= 1'b1;
            oe_reg    <= 1'b1;
            we_reg    <= 1'b1;
            drive_reg <= 1'b0;
        end else begin
            pcnt_reg  <= pcnt_next;
            tmo_reg   <= tmo_next;
            rdata_reg <= rdata_next;
            dout_reg  <= dout_next;
            addr_reg  <= addr_next;
            err_reg   <= err_next;
            ready_reg <= ready_next;
            busy_reg  <= busy_next;
            rdn_reg   <= rdn_next;
            wrn_reg   <= wrn_next;
            en_reg    <= en_next;
            oe_reg    <= oe_next;
            we_reg    <= we_next;
            drive_reg <= drive_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bus
            assign ram1Data[gi] = drive_reg ? dout_reg[gi] : 1'bz;
        end
    endgenerate

    assign rdata    = rdata_reg;
    assign ready    = ready_reg;
    assign busy     = busy_reg;
    assign err      = err_reg;
    assign rdn      = rdn_reg;
    assign wrn      = wrn_reg;
    assign ram1En   = en_reg;
    assign ram1Oe   = oe_reg;
    assign ram1We   = we_reg;
    assign ram1Addr = addr_reg;

endmodule

// File: doc/uart_ram1_ctrl.md
# uart_ram1_ctrl

Sequencer that owns the shared RAM1 data bus and the CPLD UART strobes. It accepts single-word CPU load/store requests and decodes them to RAM1, the UART data register or the UART status register. It generates `ram1En`/`ram1Oe`/`ram1We`, `rdn` and `wrn` with fixed pulse widths, and waits on `tbre`/`tsre`/`dataReady` handshakes. It sits between the memory stage and the board pins and replaces direct switch-driven strobing.

## Interface
- `RAM_CYC`, 2: cycles RAM1 enable/strobe held low per access (≥1).
- `WR_PULSE`, 2: cycles `wrn` held low (≥1).
- `RD_PULSE`, 2: cycles `rdn` held low (≥1).
- `UART_DATA_ADDR`, 16'hBF00: UART data register address.
- `UART_STAT_ADDR`, 16'hBF01: UART status register address.
- `TIMEOUT`, 1024: handshake wait bound, used only with `UART_TIMEOUT_EN`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `req` in 1: access request; sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `addr` in 16: word address.
- `wdata` in 16: store data; UART uses `[7:0]`.
- `rdata` out 16: load result; valid while `ready` is high, held until the next load completes.
- `ready` out 1: one-cycle completion pulse.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: one-cycle pulse, coincident with `ready`, on timeout.
- `tbre`, `tsre`, `dataReady` in 1 each: CPLD UART status.
- `rdn`, `wrn` out 1 each: active-low UART strobes.
- `ram1En`, `ram1Oe`, `ram1We` out 1 each: active-low RAM1 controls.
- `ram1Addr` out 18: `{2'b00, addr}`, latched at request acceptance.
- `ram1Data` inout 16: shared bus.

## Operation
- Reset values:
  - state IDLE.
  - `rdn`, `wrn`, `ram1En`, `ram1Oe`, `ram1We` = 1.
  - `ram1Data` = Z.
  - `rdata` = 0, `ready` = 0, `busy` = 0, `err` = 0, `ram1Addr` = 0.
- IDLE: when `req`=1, latch `addr`, `we` and `wdata`, then decode:
  - address is neither UART register → RAM_RD or RAM_WR.
  - `UART_DATA_ADDR` with `we`=1 → U_WR_SETUP.
  - `UART_DATA_ADDR` with `we`=0 → U_RD_WAIT.
  - `UART_STAT_ADDR` load → DONE, with `rdata={14'b0, dataReady, tbre&tsre}` sampled on the accepting edge.
  - `UART_STAT_ADDR` store → DONE, no side effect.
- RAM_RD: `ram1En`=`ram1Oe`=0 for `RAM_CYC` cycles. `rdata` is captured from `ram1Data` on the last edge, then DONE.
- RAM_WR: `ram1En`=`ram1We`=0 and bus driven with `wdata` for `RAM_CYC` cycles, then DONE.
- U_WR_SETUP (1 cycle): `ram1Data={8'h00, wdata[7:0]}` driven, `wrn`=1.
- U_WR_PULSE (`WR_PULSE` cycles): `wrn`=0, data still driven.
- U_WR_TBRE → U_WR_TSRE: bus released, `wrn`=1. Wait for `tbre`=1, then `tsre`=1, then DONE.
- U_RD_WAIT: wait for `dataReady`=1, then U_RD_PULSE.
- U_RD_PULSE (`RD_PULSE` cycles): `rdn`=0. `rdata={8'h00, ram1Data[7:0]}` is captured on the last edge, then DONE.
- DONE (1 cycle): `ready`=1, next state IDLE.
- Bus and strobe rules:
  - `ram1Data` is driven only in RAM_WR, U_WR_SETUP and U_WR_PULSE.
  - `ram1En`=1 in every UART state, so `rdn`/`wrn` low never overlaps `ram1En` low.
  - All control outputs are registered (glitch-free).
- Counters: the pulse counter reloads on each state entry. The timeout counter is 16 bits and saturates.

## Timing
- `req` accepted at edge E0; `busy` rises after E0; `ready` is high in the cycle after DONE is entered.
- Latencies from E0 to the `ready` cycle:
  - status load: 1 cycle.
  - RAM access: `RAM_CYC`+1 cycles.
  - UART write: 1+`WR_PULSE`+(tbre wait ≥1)+(tsre wait ≥1)+1 cycles.
  - UART read: (dataReady wait ≥1)+`RD_PULSE`+1 cycles.
- Handshake sampling: `tbre` is sampled only in U_WR_TBRE, so a `tbre` already high at entry passes in 1 cycle. Same rule for `tsre` and `dataReady`.
- `req` while busy is ignored; the requester holds `req` until `ready`.
- Asynchronous reset mid-operation: strobes deassert and the bus tri-states immediately, with no `ready` pulse.

## Configuration
- `UART_TIMEOUT_EN` defined:
  - U_WR_TBRE, U_WR_TSRE and U_RD_WAIT exit after `TIMEOUT` cycles without the handshake.
  - On that exit: go to DONE, `err`=1 together with `ready`, `rdata`=16'hFFFF for a read.
  - A timed-out read skips U_RD_PULSE.
- Not defined: the waits are unbounded and `err` is tied 0.

## Test plan
- Reset with `rst`=0 mid U_WR_PULSE → `wrn`=1 and `ram1Data`=Z asynchronously; state IDLE after release.
- RAM store `addr`=16'h1234, `wdata`=16'hA5A5, then load of the same address with the model echoing → `ram1We` low for 2 cycles, load `rdata`=16'hA5A5, `ready` at E0+3 for each.
- UART store `wdata`=16'h0041, `tbre` rises 3 cycles after `wrn` returns high, `tsre` 2 cycles later → `wrn` low for exactly 2 cycles with 8'h41 on the bus, `ready` one cycle after `tsre`, `ram1En`=1 throughout.
- UART load with `dataReady`=0 for 10 cycles, bus 8'h5A → `rdn` stays 1 until `dataReady`, then low for 2 cycles, `rdata`=16'h005A.
- Status load with `dataReady`=1, `tbre`=1, `tsre`=0 → `rdata`=16'h0002 at E0+1.
- With `UART_TIMEOUT_EN` and `TIMEOUT`=16, UART load with `dataReady` stuck at 0 → `ready` and `err` pulse together at E0+17, `rdata`=16'hFFFF, `rdn` never low.
